// File: rtl/if_prefetch.sv
// Instruction-fetch prefetch queue: issues sequential ROM fetches, buffers responses, handles redirects.
// Optional IF_PREFETCH_STATS_EN adds saturating flush/stall performance counters.
module if_prefetch #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset_n,
    output logic [XLEN-1:0] i_address,
    output logic            i_req,
    input  logic            i_data_valid,
    input  logic [XLEN-1:0] i_data_read,
    input  logic            redir_id,
    input  logic [XLEN-1:0] redir_id_pc,
    input  logic            redir_ex,
    input  logic [XLEN-1:0] redir_ex_pc,
    output logic            inst_valid,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] inst_pc,
    input  logic            inst_ready,
`ifdef IF_PREFETCH_STATS_EN
    output logic [15:0]     perf_flush_cnt,
    output logic [15:0]     perf_stall_cnt,
`endif
    output logic            o_dbg_state
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW+1:0] DEPTH_L = (AW+2)'(DEPTH);

    typedef enum logic {ST_BOOT = 1'b0, ST_FETCH = 1'b1} state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [XLEN-1:0] r_fetch_pc;
    logic [XLEN-1:0] r_req_pc;
    logic            r_inflight;
    logic [AW:0]     r_count;
    logic [AW-1:0]   r_wptr;
    logic [AW-1:0]   r_rptr;
    logic [XLEN-1:0] r_q_inst [DEPTH];
    logic [XLEN-1:0] r_q_pc   [DEPTH];

    logic            w_redir;
    logic [XLEN-1:0] w_target;
    logic            w_req;
    logic [XLEN-1:0] w_addr;
    logic            w_push;
    logic            w_pop;
    logic [XLEN-1:0] w_fetch_pc_nxt;
    logic [AW+1:0]   w_occ;

    // The in-flight response reserves a slot, so the queue can never overflow.
    assign w_occ = {1'b0, r_count} + {{(AW+1){1'b0}}, r_inflight};

    always_comb begin
        w_state_nxt    = r_state;
        w_redir        = 1'b0;
        w_target       = '0;
        w_req          = 1'b0;
        w_addr         = r_fetch_pc;
        w_push         = 1'b0;
        w_fetch_pc_nxt = r_fetch_pc;
        case (r_state)
            ST_BOOT: w_state_nxt = ST_FETCH;
            ST_FETCH: begin
                if (redir_ex) begin
                    w_redir  = 1'b1;
                    w_target = redir_ex_pc;
                end else if (redir_id) begin
                    w_redir  = 1'b1;
                    w_target = redir_id_pc;
                end
                if (w_redir) begin
                    w_req          = 1'b1;
                    w_addr         = w_target;
                    w_fetch_pc_nxt = w_target + XLEN'(4);
                end else if (r_inflight && !i_data_valid) begin
                    // Missed response: rewind and stay idle this cycle to keep order.
                    w_fetch_pc_nxt = r_req_pc;
                end else begin
                    w_push = r_inflight;
                    w_req  = (w_occ < DEPTH_L);
                    if (w_req) w_fetch_pc_nxt = r_fetch_pc + XLEN'(4);
                end
            end
            default: w_state_nxt = ST_BOOT;
        endcase
    end

    assign w_pop       = inst_valid && inst_ready && !w_redir;
    assign inst_valid  = (r_count != '0);
    assign inst        = r_q_inst[r_rptr];
    assign inst_pc     = r_q_pc[r_rptr];
    assign i_req       = w_req;
    assign i_address   = w_addr;
    assign o_dbg_state = r_state;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_BOOT;
            r_fetch_pc <= RESET_PC;
            r_req_pc   <= RESET_PC;
            r_inflight <= 1'b0;
            r_count    <= '0;
            r_wptr     <= '0;
            r_rptr     <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_fetch_pc <= w_fetch_pc_nxt;
            r_inflight <= w_req;
            if (w_req) r_req_pc <= w_addr;
            if (w_redir) begin
                r_count <= '0;
                r_wptr  <= '0;
                r_rptr  <= '0;
            end else begin
                if (w_push) r_wptr <= r_wptr + AW'(1);
                if (w_pop)  r_rptr <= r_rptr + AW'(1);
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + (AW+1)'(1);
                    2'b01:   r_count <= r_count - (AW+1)'(1);
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_inst[r_wptr] <= i_data_read;
            r_q_pc[r_wptr]   <= r_req_pc;
        end
    end

`ifdef IF_PREFETCH_STATS_EN
    logic w_stall;
    assign w_stall = (r_state == ST_FETCH) && !w_req;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_flush_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (w_redir && perf_flush_cnt != 16'hFFFF) perf_flush_cnt <= perf_flush_cnt + 16'd1;
            if (w_stall && perf_stall_cnt != 16'hFFFF) perf_stall_cnt <= perf_stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: doc/if_prefetch.md
IF_PREFETCH -- requirements
Module: if_prefetch

Interface
REQ-001 SHALL have parameters: XLEN, 32, instruction/address width; DEPTH, 4, queue entries (power of two, 2..16); RESET_PC, 0, first fetch address.
REQ-002 SHALL have ports (clk, reset_n first): clk  in  1  single clock, rising edge; reset_n  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have ROM ports: i_address  out  XLEN  fetch byte address; i_req  out  1  fetch issued this cycle; i_data_valid  in  1  i_data_read holds the response to the previous-cycle request; i_data_read  in  XLEN  instruction word.
REQ-004 SHALL have redirect ports: redir_id  in  1  decode-stage jump; redir_id_pc  in  XLEN  its target; redir_ex  in  1  execute-stage jump; redir_ex_pc  in  XLEN  its target.
REQ-005 SHALL have consumer ports: inst_valid  out  1  queue head valid; inst  out  XLEN  head instruction; inst_pc  out  XLEN  head address; inst_ready  in  1  consumer accepts head.

Function
REQ-006 SHALL run FSM BOOT -> FETCH: BOOT lasts exactly one cycle after reset release with i_req=0; FETCH is permanent until the next reset.
REQ-007 SHALL, in FETCH, assert i_req when count + inflight < DEPTH, inflight (0/1) being the request issued in the previous cycle.
REQ-008 SHALL advance fetch_pc by 4 (modulo 2^XLEN) per issued request; i_address SHALL equal fetch_pc.
REQ-009 SHALL push {i_data_read, address of the previous-cycle request} into the queue when inflight=1 and i_data_valid=1 and no redirect is active.
REQ-010 SHALL, when inflight=1 and i_data_valid=0, drop the response and rewind fetch_pc to the missed address so it is reissued; no request SHALL be issued in that cycle.
REQ-011 SHALL pop the head when inst_valid and inst_ready are both 1; a simultaneous push and pop SHALL leave count unchanged, including when full.
REQ-012 SHALL keep inst/inst_pc stable while inst_valid=1 and inst_ready=0.
REQ-013 SHALL, on redir_ex or redir_id, flush the queue, discard the response arriving that cycle, and issue the target in the same cycle (i_address=target, i_req=1).
REQ-014 SHALL give redir_ex priority over redir_id when both are asserted.
REQ-015 SHALL ignore redirects during BOOT; the queue SHALL never overflow or underflow.
REQ-016 SHALL produce first inst_valid no earlier than 2 cycles after BOOT exit: issue, then push; visible the cycle after push.

Reset
REQ-017 SHALL, while reset_n=0: state=BOOT, fetch_pc=RESET_PC, count=0, inflight=0, i_req=0, inst_valid=0, i_address=RESET_PC.
REQ-018 SHALL treat reset asserted mid-operation as an immediate flush, abandoning any in-flight response.

Configuration
REQ-019 SHALL, with IF_PREFETCH_STATS_EN defined, add outputs perf_flush_cnt (16 bit, +1 per redirect taken) and perf_stall_cnt (16 bit, +1 per FETCH cycle with i_req=0), both saturating at 16'hFFFF and reset to 0.
REQ-020 SHALL, without IF_PREFETCH_STATS_EN, omit those ports and counters entirely, with all other behaviour identical.

Verification
REQ-021 Reset release with ROM always valid and inst_ready=1 -> i_address 0,4,8,... and inst_pc 0,4,8 delivered once each, with no duplicate at address 0.
REQ-022 DEPTH=4, inst_ready=0 -> exactly 4 entries pushed, i_req=0 thereafter; inst_ready=1 for one cycle -> a single new request issued.
REQ-023 i_data_valid=0 for the response to 0x10 -> 0x10 reissued next cycle; inst_pc order 0x0C, 0x10, 0x14 with no gap.
REQ-024 redir_id=1 (0x100) and redir_ex=1 (0x200) in the same cycle -> queue flushed, i_address=0x200 that cycle, next inst_pc=0x200.
REQ-025 fetch_pc=0xFFFFFFFC -> next i_address=0x00000000.
REQ-026 With IF_PREFETCH_STATS_EN, 3 redirects -> perf_flush_cnt=3; reset_n pulsed low mid-stream -> all outputs at reset values immediately and counters=0.
